// File: rtl/simd_alu_pkg.sv
// Shared definitions for the pipelined SIMD three-operand adder.
//   MODE_*      : lane-split selector encodings carried on use_simd
//   lane_start  : 1 when segment idx is the lowest segment of a lane
//   lane_top    : 1 when segment idx is the highest segment of a lane
// The lane sizes are passed in so the helpers stay usable for any
// parametrisation of the top.
package simd_alu_pkg;

  localparam logic [1:0] MODE_FULL = 2'd0;  // one lane over the whole datapath
  localparam logic [1:0] MODE_M1   = 2'd1;  // lanes of LANE_M1 segments
  localparam logic [1:0] MODE_M2   = 2'd2;  // lanes of LANE_M2 segments
  localparam logic [1:0] MODE_SEG  = 2'd3;  // every segment is its own lane

  function automatic logic lane_start(input int idx, input logic [1:0] mode,
                                      input int num_seg, input int lane_m1,
                                      input int lane_m2);
    logic r;
    r = 1'b0;
    case (mode)
      MODE_FULL: r = ((idx % num_seg) == 0);
      MODE_M1:   r = ((idx % lane_m1) == 0);
      MODE_M2:   r = ((idx % lane_m2) == 0);
      MODE_SEG:  r = 1'b1;
      default:   r = 1'b1;
    endcase
    return r;
  endfunction

  // The top of a lane is the segment right below the next lane start,
  // or the last segment of the datapath.
  function automatic logic lane_top(input int idx, input logic [1:0] mode,
                                    input int num_seg, input int lane_m1,
                                    input int lane_m2);
    return (idx == num_seg - 1) ||
           lane_start(idx + 1, mode, num_seg, lane_m1, lane_m2);
  endfunction

endpackage

// File: rtl/simd_alu_seg.sv
// One carry-save segment cell: {cout,sum} = a + b + c + cin.
//   a, b, c : SEG_W-bit operands
//   cin     : 2-bit carry-in (0..3)
//   sum     : SEG_W-bit segment sum
//   cout    : 2-bit carry-out; max total is 3*(2^SEG_W-1)+3 = 3*2^SEG_W,
//             so two carry bits are always enough.
module simd_alu_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic [SEG_W-1:0] c,
  input  logic [1:0]       cin,
  output logic [SEG_W-1:0] sum,
  output logic [1:0]       cout
);

  logic [SEG_W+1:0] total;

  assign total = {2'b00, a} + {2'b00, b} + {2'b00, c} + {{SEG_W{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/simd_alu_acc_pipe.sv
// Pipelined SIMD three-operand adder with per-lane accumulation.
// Computes s = W + X + Y + cin over NUM_SEG segments, with the carry
// chain cut into lanes by use_simd. W is replaced by the previous result
// (acc_en) or zero (acc_clr). The adder always sits in the final stage;
// IN_REG adds an input register stage in front of it.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   use_simd[1:0]     : lane mode (see simd_alu_pkg MODE_*)
//   in_valid          : qualifies all other inputs
//   acc_en, acc_clr   : accumulate / clear feedback and sticky overflow
//   cin               : carry into segment 0, mode 0 only
//   w, x, y [DW-1:0]  : operands
//   s [DW-1:0]        : registered sum
//   cout_seg[2*NS-1:0]: registered 2-bit carry-out per segment
//   lane_ovf[NS-1:0]  : sticky overflow at each lane's top segment
//   out_valid         : outputs updated this cycle
module simd_alu_acc_pipe
  import simd_alu_pkg::*;
#(
  parameter int SEG_W   = 4,
  parameter int NUM_SEG = 12,
  parameter int LANE_M1 = 4,
  parameter int LANE_M2 = 2,
  parameter int IN_REG  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               use_simd,
  input  logic                     in_valid,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  input  logic                     cin,
  input  logic [SEG_W*NUM_SEG-1:0] w,
  input  logic [SEG_W*NUM_SEG-1:0] x,
  input  logic [SEG_W*NUM_SEG-1:0] y,
  output logic [SEG_W*NUM_SEG-1:0] s,
  output logic [2*NUM_SEG-1:0]     cout_seg,
  output logic [NUM_SEG-1:0]       lane_ovf,
  output logic                     out_valid
);

  localparam int DW = SEG_W * NUM_SEG;

  logic          vld_p0;
  logic [1:0]    mode_p0;
  logic          en_p0;
  logic          clr_p0;
  logic          cin_p0;
  logic [DW-1:0] w_p0;
  logic [DW-1:0] x_p0;
  logic [DW-1:0] y_p0;

  // ---- stage p0: input capture (registered or pass-through) ----
  if (IN_REG != 0) begin : g_in_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p0  <= 1'b0;
        mode_p0 <= MODE_FULL;
        en_p0   <= 1'b0;
        clr_p0  <= 1'b0;
        cin_p0  <= 1'b0;
        w_p0    <= '0;
        x_p0    <= '0;
        y_p0    <= '0;
      end else begin
        vld_p0 <= in_valid;
        // Data only moves with a valid sample; invalid cycles never reach the adder.
        if (in_valid) begin
          mode_p0 <= use_simd;
          en_p0   <= acc_en;
          clr_p0  <= acc_clr;
          cin_p0  <= cin;
          w_p0    <= w;
          x_p0    <= x;
          y_p0    <= y;
        end
      end
    end
  end else begin : g_in_comb
    assign vld_p0  = in_valid;
    assign mode_p0 = use_simd;
    assign en_p0   = acc_en;
    assign clr_p0  = acc_clr;
    assign cin_p0  = cin;
    assign w_p0    = w;
    assign x_p0    = x;
    assign y_p0    = y;
  end

  // ---- stage p1: accumulator feedback, segmented adder, output registers ----
  logic [DW-1:0]        op_w_p0;
  logic [DW-1:0]        sum_p0;
  logic [2*NUM_SEG-1:0] cout_p0;
  logic [NUM_SEG-1:0]   top_ovf_p0;

  // s already holds the previous accepted sample's result, so back-to-back
  // accumulation needs no forwarding path.
  assign op_w_p0 = clr_p0 ? '0 : (en_p0 ? s : w_p0);

  for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
    logic [1:0] cin2;
    logic [1:0] cout;
    logic       start;
    logic       top;

    assign start = lane_start(i, mode_p0, NUM_SEG, LANE_M1, LANE_M2);
    assign top   = lane_top(i, mode_p0, NUM_SEG, LANE_M1, LANE_M2);

    // Each segment keeps its own carry signals so the ripple chain is a
    // sequence of distinct nets rather than a self-referencing vector.
    if (i == 0) begin : g_first
      assign cin2 = (mode_p0 == MODE_FULL) ? {1'b0, cin_p0} : 2'b00;
    end else begin : g_rest
      assign cin2 = start ? 2'b00 : g_seg[i-1].cout;
    end

    simd_alu_seg #(.SEG_W(SEG_W)) u_seg (
      .a    (op_w_p0[i*SEG_W +: SEG_W]),
      .b    (x_p0[i*SEG_W +: SEG_W]),
      .c    (y_p0[i*SEG_W +: SEG_W]),
      .cin  (cin2),
      .sum  (sum_p0[i*SEG_W +: SEG_W]),
      .cout (cout)
    );

    assign cout_p0[2*i +: 2] = cout;
    assign top_ovf_p0[i]     = top && (cout != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s         <= '0;
      cout_seg  <= '0;
      lane_ovf  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        s        <= sum_p0;
        cout_seg <= cout_p0;
        // acc_clr wipes history first, then this sample's overflow is OR-ed in.
        lane_ovf <= (clr_p0 ? '0 : lane_ovf) | top_ovf_p0;
      end
    end
  end

endmodule

// File: tb/tb_simd_alu_acc_pipe.sv
module tb_simd_alu_acc_pipe;

  localparam int SEG_W   = 4;
  localparam int NUM_SEG = 12;
  localparam int DW      = 48;
  localparam int NB      = 60;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    use_simd;
  logic          in_valid, acc_en, acc_clr, cin;
  logic [DW-1:0] w, x, y, s;
  logic [23:0]   cout_seg;
  logic [11:0]   lane_ovf;
  logic          out_valid;

  int checks = 0;
  int errors = 0;

  // Reference state: result of the last accepted sample and sticky overflow.
  logic [47:0] m_s;
  logic [23:0] m_cout;
  logic [11:0] m_ovf;

  always #5 clk = ~clk;

  simd_alu_acc_pipe #(
    .SEG_W(SEG_W), .NUM_SEG(NUM_SEG), .LANE_M1(4), .LANE_M2(2), .IN_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .use_simd(use_simd), .in_valid(in_valid),
    .acc_en(acc_en), .acc_clr(acc_clr), .cin(cin), .w(w), .x(x), .y(y),
    .s(s), .cout_seg(cout_seg), .lane_ovf(lane_ovf), .out_valid(out_valid)
  );

  function automatic logic [47:0] rnd48();
    logic [47:0] r;
    r[31:0]  = $urandom();
    r[47:32] = 16'($urandom());
    return r;
  endfunction

  // Model: within a lane, the carry out of segment i is the part of the
  // lane-relative prefix sum (segments lane_start..i) above its bit width,
  // and the sum nibble is the top nibble of that prefix sum.
  task automatic model_sample(input logic [1:0] mode, input logic en, input logic clr,
                              input logic c_in, input logic [47:0] wv,
                              input logic [47:0] xv, input logic [47:0] yv);
    int L, ls, k;
    logic [63:0] we, part, mask, carry;
    logic [47:0] ns;
    logic [23:0] nc;
    logic [11:0] ov;
    L  = (mode == 2'd0) ? 12 : (mode == 2'd1) ? 4 : (mode == 2'd2) ? 2 : 1;
    we = clr ? 64'd0 : (en ? {16'd0, m_s} : {16'd0, wv});
    ns = '0; nc = '0; ov = '0;
    for (int i = 0; i < 12; i++) begin
      ls    = (i / L) * L;
      k     = i - ls + 1;
      mask  = (64'd1 << (4 * k)) - 64'd1;
      part  = ((we >> (4 * ls)) & mask) + (({16'd0, xv} >> (4 * ls)) & mask)
            + (({16'd0, yv} >> (4 * ls)) & mask)
            + ((mode == 2'd0 && c_in) ? 64'd1 : 64'd0);
      carry = part >> (4 * k);
      ns[4*i +: 4] = part[4*(k-1) +: 4];
      nc[2*i +: 2] = carry[1:0];
      if ((i % L) == L - 1 && carry != 64'd0) ov[i] = 1'b1;
    end
    m_s    = ns;
    m_cout = nc;
    m_ovf  = (clr ? 12'd0 : m_ovf) | ov;
  endtask

  task automatic apply(input logic v, input logic [1:0] mode, input logic en,
                       input logic clr, input logic c_in, input logic [47:0] wv,
                       input logic [47:0] xv, input logic [47:0] yv);
    in_valid = v; use_simd = mode; acc_en = en; acc_clr = clr; cin = c_in;
    w = wv; x = xv; y = yv;
    if (v) model_sample(mode, en, clr, c_in, wv, xv, yv);
  endtask

  // Invalid cycle carrying random junk that must be ignored.
  task automatic idle();
    apply(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd48(), rnd48(), rnd48());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_s = '0; m_cout = '0; m_ovf = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    checks++; if (s !== 48'd0) begin errors++; $display("FAIL reset_s: got %h want 0", s); end
    checks++; if (cout_seg !== 24'd0) begin errors++; $display("FAIL reset_cout: got %h want 0", cout_seg); end
    checks++; if (lane_ovf !== 12'd0) begin errors++; $display("FAIL reset_ovf: got %h want 0", lane_ovf); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    reset = 1'b0;
    m_s = '0; m_cout = '0; m_ovf = '0;
  endtask

  task automatic test_full_ripple();
    do_reset();
    @(negedge clk); apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 48'd0, 48'd0, 48'hFFFF_FFFF_FFFF);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ripple_lat1: got %b want 0", out_valid); end
    idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ripple_lat2: got %b want 1", out_valid); end
    checks++; if (s !== 48'd0) begin errors++; $display("FAIL ripple_s: got %h want 0", s); end
    checks++; if (cout_seg[23:22] !== 2'b01) begin errors++; $display("FAIL ripple_cout_top: got %b want 01", cout_seg[23:22]); end
    checks++; if (lane_ovf[11] !== 1'b1) begin errors++; $display("FAIL ripple_ovf11: got %b want 1", lane_ovf[11]); end
    checks++; if (cout_seg !== m_cout || lane_ovf !== m_ovf) begin
      errors++; $display("FAIL ripple_model: cout %h ovf %h want %h %h", cout_seg, lane_ovf, m_cout, m_ovf); end
    idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ripple_lat3: got %b want 0", out_valid); end
  endtask

  task automatic test_per_seg();
    do_reset();
    @(negedge clk); apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (s !== 48'hDDDD_DDDD_DDDD) begin errors++; $display("FAIL perseg_s: got %h want DDDDDDDDDDDD", s); end
    checks++; if (cout_seg !== 24'hAAAAAA) begin errors++; $display("FAIL perseg_cout: got %h want AAAAAA", cout_seg); end
    checks++; if (lane_ovf !== 12'hFFF) begin errors++; $display("FAIL perseg_ovf: got %h want FFF", lane_ovf); end
    checks++; if (s !== m_s) begin errors++; $display("FAIL perseg_model: got %h want %h", s, m_s); end
  endtask

  task automatic test_mode1_cut();
    do_reset();
    @(negedge clk); apply(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 48'h0000_0000_FFFF, 48'd1, 48'd0);
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (s !== m_s) begin errors++; $display("FAIL m1_s: got %h want %h", s, m_s); end
    checks++; if (s[19:16] !== 4'h0) begin errors++; $display("FAIL m1_nocarry_seg4: got %h want 0", s[19:16]); end
    checks++; if (cout_seg[7:6] !== 2'b01) begin errors++; $display("FAIL m1_cout3: got %b want 01", cout_seg[7:6]); end
    checks++; if (cout_seg[9:8] !== 2'b00) begin errors++; $display("FAIL m1_cout4: got %b want 00", cout_seg[9:8]); end
    checks++; if (lane_ovf !== 12'h008) begin errors++; $display("FAIL m1_ovf: got %h want 008", lane_ovf); end
  endtask

  task automatic test_accumulate();
    logic [7:0]  b;
    logic [47:0] exp_s;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        b = 8'(c - 2);
        exp_s = {6{b}};
        checks++;
        if (out_valid !== 1'b1 || s !== exp_s) begin
          errors++; $display("FAIL acc_step%0d: valid %b s %h want 1 %h", c - 2, out_valid, s, exp_s);
        end
      end
      if (c == 0)     apply(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 48'd1, 48'd0, 48'd0);
      else if (c < 4) apply(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, rnd48(), 48'h0101_0101_0101, 48'd0);
      else            idle();
    end
  endtask

  task automatic test_mode_switch();
    logic [47:0] ea, eb;
    do_reset();
    @(negedge clk); apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, rnd48(), rnd48(), rnd48()); ea = m_s;
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || s !== ea) begin
      errors++; $display("FAIL sw_first: valid %b s %h want 1 %h", out_valid, s, ea); end
    apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, rnd48(), rnd48(), rnd48()); eb = m_s;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || s !== ea) begin
      errors++; $display("FAIL sw_bubble_hold: valid %b s %h want 0 %h", out_valid, s, ea); end
    idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || s !== eb || cout_seg !== m_cout || lane_ovf !== m_ovf) begin
      errors++; $display("FAIL sw_second: valid %b s %h cout %h ovf %h want 1 %h %h %h",
                         out_valid, s, cout_seg, lane_ovf, eb, m_cout, m_ovf); end
  endtask

  task automatic test_back_to_back();
    logic        ev [NB+2];
    logic [47:0] es [NB+2];
    logic [23:0] ec [NB+2];
    logic [11:0] eo [NB+2];
    logic        v;
    do_reset();
    for (int c = 0; c < NB + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++;
        if (out_valid !== ev[c-2] || s !== es[c-2] || cout_seg !== ec[c-2] || lane_ovf !== eo[c-2]) begin
          errors++;
          $display("FAIL b2b_cyc%0d: valid %b s %h cout %h ovf %h want %b %h %h %h", c, out_valid, s,
                   cout_seg, lane_ovf, ev[c-2], es[c-2], ec[c-2], eo[c-2]);
        end
      end
      if (c < NB) begin
        v = ($urandom_range(0, 3) != 0);
        apply(v, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), rnd48(), rnd48(), rnd48());
      end else begin
        v = 1'b0;
        idle();
      end
      ev[c] = v; es[c] = m_s; ec[c] = m_cout; eo[c] = m_ovf;
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    @(negedge clk); apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
    @(negedge clk); idle();
    @(negedge clk); apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, rnd48(), rnd48(), rnd48());
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    checks++; if (s !== 48'd0 || cout_seg !== 24'd0 || lane_ovf !== 12'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_clear: s %h cout %h ovf %h valid %b want all 0", s, cout_seg, lane_ovf, out_valid); end
    @(negedge clk);
    reset = 1'b0;
    m_s = '0; m_cout = '0; m_ovf = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_novalid%0d: got %b want 0", c, out_valid); end
      if (c == 2) apply(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, rnd48(), rnd48(), rnd48());
      else        idle();
    end
    @(negedge clk); idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || s !== m_s || cout_seg !== m_cout || lane_ovf !== m_ovf) begin
      errors++; $display("FAIL midrst_after: valid %b s %h cout %h ovf %h want 1 %h %h %h",
                         out_valid, s, cout_seg, lane_ovf, m_s, m_cout, m_ovf); end
  endtask

  initial begin
    test_reset();
    test_full_ripple();
    test_per_seg();
    test_mode1_cut();
    test_accumulate();
    test_mode_switch();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
